maze_generator: RTL and testbench



---
 rtl/maze_pkg.sv | 37 +++
 rtl/maze_lfsr.sv | 29 ++
 rtl/maze_generator.sv | 158 +++++++++++++++
 tb/tb_maze_generator.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze generator: direction and FSM
// encodings, LFSR taps/seed, and cell-index to maze-coordinate mapping.
package maze_pkg;

  typedef enum logic [2:0] {
    RIGHT = 3'd0,
    LEFT  = 3'd1,
    DOWN  = 3'd2,
    UP    = 3'd3,
    NONE  = 3'd4
  } dir_e;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    CARVE,
    OPEN,
    DONE
  } state_e;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef struct packed {
    logic [15:0] y;
    logic [15:0] x;
  } xy_t;

  function automatic xy_t cell_to_xy(input int unsigned idx, input int unsigned c);
    xy_t r;
    r.x = 16'(2 * (idx % c) + 1);
    r.y = 16'(2 * (idx / c) + 1);
    return r;
  endfunction

endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Fibonacci LFSR; a zero seed is replaced by DEFAULT_SEED so the
// register can never lock up. Only the two low bits are consumed.
module maze_lfsr #(
  parameter logic [15:0] DEFAULT_SEED = maze_pkg::DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed_in,
  input  logic        advance,
  output logic [1:0]  lfsr_lo
);
  import maze_pkg::*;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= DEFAULT_SEED;
    end else if (load) begin
      lfsr_q <= (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  assign lfsr_lo = lfsr_q[1:0];

endmodule

// File: rtl/maze_generator.sv
// Recursive-backtracker maze generator: carves a perfect maze into a
// size x size wall bitmap (1=wall), one DFS step per clock.
module maze_generator #(
  parameter int unsigned size         = 9,
  parameter int unsigned N            = 4,
  parameter logic [15:0] DEFAULT_SEED = maze_pkg::DEFAULT_SEED
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               seed,
  output logic [size-1:0][size-1:0] maze,
  output logic                      busy,
  output logic                      done,
  output logic [N-1:0]              x,
  output logic [N-1:0]              y
);
  import maze_pkg::*;

  localparam int unsigned C     = (size - 1) / 2;
  localparam int unsigned CELLS = C * C;
  localparam int unsigned CW    = $clog2(CELLS);
  localparam int unsigned SPW   = $clog2(CELLS + 1);

  // All walls set, every odd/odd cell position open.
  localparam logic [size-1:0]            ODD_ROW   = {{C{2'b10}}, 1'b1};
  localparam logic [size-1:0][size-1:0]  INIT_MAZE = {{size{1'b1}}, {C{ODD_ROW, {size{1'b1}}}}};

  state_e                   state_q;
  logic [size-1:0][size-1:0] maze_q;
  logic                     busy_q, done_q;
  logic [N-1:0]             x_q, y_q;
  logic [CELLS-1:0]         visited_q;
  logic [CW-1:0]            stack_q [CELLS];
  logic [SPW-1:0]           sp_q;

  logic [1:0]    lfsr_lo;
  logic          accept;
  logic [CW-1:0] top_ptr, top_cell;
  xy_t           top_xy;
  logic [3:0]    avail;
  logic [CW-1:0] nidx [4];
  logic          nb_found;
  logic [1:0]    nb_d;
  dir_e          nb_dir;
  logic [CW-1:0] nb_idx;
  logic [N-1:0]  wall_x, wall_y, nb_x, nb_y;

  assign accept = (state_q == IDLE || state_q == DONE) && start;

  maze_lfsr #(.DEFAULT_SEED(DEFAULT_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .seed_in (seed),
    .advance (state_q == CARVE),
    .lfsr_lo (lfsr_lo)
  );

  always_comb begin
    top_ptr  = CW'(sp_q - SPW'(1));
    top_cell = stack_q[top_ptr];
    top_xy   = cell_to_xy(32'(top_cell), C);

    nidx[0] = top_cell + CW'(1);
    nidx[1] = top_cell - CW'(1);
    nidx[2] = top_cell + CW'(C);
    nidx[3] = top_cell - CW'(C);
    avail[0] = (top_xy.x < 16'(size - 2)) && !visited_q[nidx[0]];
    avail[1] = (top_xy.x > 16'd1)         && !visited_q[nidx[1]];
    avail[2] = (top_xy.y < 16'(size - 2)) && !visited_q[nidx[2]];
    avail[3] = (top_xy.y > 16'd1)         && !visited_q[nidx[3]];

    // Scan starts at the random direction and rotates through all four.
    nb_found = 1'b0;
    nb_d     = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!nb_found && avail[lfsr_lo + 2'(k)]) begin
        nb_found = 1'b1;
        nb_d     = lfsr_lo + 2'(k);
      end
    end
    nb_dir = nb_found ? dir_e'({1'b0, nb_d}) : NONE;
    nb_idx = nidx[nb_d];

    wall_x = N'(top_xy.x);
    wall_y = N'(top_xy.y);
    nb_x   = N'(top_xy.x);
    nb_y   = N'(top_xy.y);
    case (nb_dir)
      RIGHT: begin wall_x = N'(top_xy.x + 16'd1); nb_x = N'(top_xy.x + 16'd2); end
      LEFT:  begin wall_x = N'(top_xy.x - 16'd1); nb_x = N'(top_xy.x - 16'd2); end
      DOWN:  begin wall_y = N'(top_xy.y + 16'd1); nb_y = N'(top_xy.y + 16'd2); end
      UP:    begin wall_y = N'(top_xy.y - 16'd1); nb_y = N'(top_xy.y - 16'd2); end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      maze_q    <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      visited_q <= '0;
      sp_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= INIT;
          end
        end
        INIT: begin
          maze_q     <= INIT_MAZE;
          visited_q  <= CELLS'(1);
          stack_q[0] <= '0;
          sp_q       <= SPW'(1);
          x_q        <= N'(1);
          y_q        <= N'(1);
          state_q    <= CARVE;
        end
        CARVE: begin
          if (nb_found) begin
            maze_q[wall_y][wall_x] <= 1'b0;
            visited_q[nb_idx]      <= 1'b1;
            stack_q[CW'(sp_q)]     <= nb_idx;
            sp_q                   <= sp_q + SPW'(1);
            x_q                    <= nb_x;
            y_q                    <= nb_y;
          end else begin
            sp_q <= sp_q - SPW'(1);
            if (sp_q == SPW'(1)) state_q <= OPEN;
          end
        end
        OPEN: begin
          maze_q[0][1]           <= 1'b0;
          maze_q[size-1][size-2] <= 1'b0;
          done_q                 <= 1'b1;
          busy_q                 <= 1'b0;
          state_q                <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign maze = maze_q;
  assign busy = busy_q;
  assign done = done_q;
  assign x    = x_q;
  assign y    = y_q;

endmodule

// File: tb/tb_maze_generator.sv
// Scoreboard bench for maze_generator: stimulus pushes reference mazes from
// a behavioural DFS model; a monitor pops and checks on each done rise.
module tb_maze_generator;

  localparam int SZ    = 9;
  localparam int C     = 4;
  localparam int CELLS = 16;
  localparam int LAT   = 2 * CELLS + 1;

  typedef logic [SZ-1:0][SZ-1:0] maze_t;
  typedef struct {
    maze_t       m;
    int          start_edge;
    logic [15:0] seed;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] seed = 16'h0000;
  maze_t       maze;
  logic        busy, done;
  logic [3:0]  x, y;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  exp_t  sb[$];
  maze_t last_exp = '1;

  maze_generator #(.size(SZ), .N(4), .DEFAULT_SEED(16'hACE1)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .seed  (seed),
    .maze  (maze),
    .busy  (busy),
    .done  (done),
    .x     (x),
    .y     (y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    logic fb;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    return {v[14:0], fb};
  endfunction

  // Reference recursive backtracker over a C x C cell grid.
  function automatic maze_t gen_maze(input logic [15:0] s);
    maze_t m;
    logic [15:0] r;
    bit [CELLS-1:0] vis;
    int stk[$];
    int dx[4] = '{1, -1, 0, 0};
    int dy[4] = '{0, 0, 1, -1};
    int cur, cx, cy, d, ncx, ncy;
    bit found;
    r = (s == 16'h0000) ? 16'hACE1 : s;
    for (int yy = 0; yy < SZ; yy++)
      for (int xx = 0; xx < SZ; xx++)
        m[yy][xx] = !((yy % 2 == 1) && (xx % 2 == 1));
    vis = '0;
    vis[0] = 1'b1;
    stk.push_back(0);
    while (stk.size() > 0) begin
      cur = stk[stk.size() - 1];
      cx = cur % C;
      cy = cur / C;
      found = 0;
      for (int k = 0; k < 4; k++) begin
        if (!found) begin
          d = (int'(r[1:0]) + k) % 4;
          ncx = cx + dx[d];
          ncy = cy + dy[d];
          if (ncx >= 0 && ncx < C && ncy >= 0 && ncy < C && !vis[ncy * C + ncx]) begin
            m[2 * cy + 1 + dy[d]][2 * cx + 1 + dx[d]] = 1'b0;
            vis[ncy * C + ncx] = 1'b1;
            stk.push_back(ncy * C + ncx);
            found = 1;
          end
        end
      end
      if (!found) void'(stk.pop_back());
      r = lfsr_next(r);
    end
    m[0][1] = 1'b0;
    m[SZ-1][SZ-2] = 1'b0;
    return m;
  endfunction

  function automatic int flood(input maze_t m, output logic [1:0] ends);
    bit seen[SZ][SZ];
    int qx[$], qy[$];
    int dx[4] = '{1, -1, 0, 0};
    int dy[4] = '{0, 0, 1, -1};
    int cnt = 0;
    int cx, cy, nx, ny;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++)
        seen[i][j] = 0;
    seen[1][1] = 1;
    qx.push_back(1);
    qy.push_back(1);
    while (qx.size() > 0) begin
      cx = qx.pop_front();
      cy = qy.pop_front();
      if (cx % 2 == 1 && cy % 2 == 1) cnt++;
      for (int k = 0; k < 4; k++) begin
        nx = cx + dx[k];
        ny = cy + dy[k];
        if (nx >= 0 && nx < SZ && ny >= 0 && ny < SZ && !seen[ny][nx] && m[ny][nx] == 1'b0) begin
          seen[ny][nx] = 1;
          qx.push_back(nx);
          qy.push_back(ny);
        end
      end
    end
    ends = {seen[0][1], seen[SZ-1][SZ-2]};
    return cnt;
  endfunction

  function automatic void struct_check(input maze_t m);
    int border0 = 0, grid_bad = 0, inner0 = 0, cells;
    logic [1:0] ends;
    for (int yy = 0; yy < SZ; yy++)
      for (int xx = 0; xx < SZ; xx++) begin
        if (yy == 0 || yy == SZ - 1 || xx == 0 || xx == SZ - 1) begin
          if (m[yy][xx] == 1'b0) border0++;
        end else if ((yy + xx) % 2 == 1) begin
          if (m[yy][xx] == 1'b0) inner0++;
        end
        if (yy % 2 == 1 && xx % 2 == 1 && m[yy][xx] != 1'b0) grid_bad++;
        if (yy % 2 == 0 && xx % 2 == 0 && m[yy][xx] != 1'b1) grid_bad++;
      end
    check("border_openings", border0, 2);
    check("entrance_exit_open", {m[0][1], m[SZ-1][SZ-2]}, 2'b00);
    check("cell_grid", grid_bad, 0);
    check("interior_open_walls", inner0, CELLS - 1);
    cells = flood(m, ends);
    check("flood_cells", cells, CELLS);
    check("flood_ends", ends, 2'b11);
  endfunction

  // Monitor: compares every done rise against the oldest expectation.
  initial begin : monitor
    logic done_prev;
    int   hold;
    exp_t e;
    done_prev = 1'b0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_done: done rose at cycle %0d, expected no result", cyc);
        end else begin
          e = sb.pop_front();
          check("done_latency", cyc - e.start_edge, LAT);
          check($sformatf("maze_seed_%04h", e.seed), maze, e.m);
          check("busy_at_done", busy, 1'b0);
          struct_check(maze);
          last_exp = e.m;
          hold = 0;
        end
      end else if (done && done_prev) begin
        hold++;
        if (hold == 3) check("maze_stable", maze, last_exp);
      end
      if (sb.size() > 0 && cyc - sb[0].start_edge > LAT + 8) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: seed %04h got no done by cycle %0d, required at %0d",
                 sb[0].seed, cyc, sb[0].start_edge + LAT);
        void'(sb.pop_front());
      end
      done_prev = done;
    end
  end

  task automatic issue(input logic [15:0] s);
    exp_t e;
    @(negedge clk);
    e.m = gen_maze(s);
    e.start_edge = cyc + 1;
    e.seed = s;
    sb.push_back(e);
    start = 1'b1;
    seed = s;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("done_after_start", done, 1'b0);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_values();
    check("rst_maze", maze, {SZ*SZ{1'b1}});
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_xy", {x, y}, 8'h00);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    issue(16'h0001); drain();
    issue(16'h0001); drain();
    issue(16'hBEEF); drain();
    issue(16'h0000); drain();
    issue(16'hACE1); drain();

    // starts while busy are ignored
    issue(16'h0001);
    repeat (4) @(negedge clk);
    start = 1'b1; seed = 16'h1234;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; seed = 16'h4321;
    @(negedge clk);
    start = 1'b0;
    drain();

    // start held high: back-to-back mazes 34 edges apart
    @(negedge clk);
    e.m = gen_maze(16'h2468);
    e.seed = 16'h2468;
    e.start_edge = cyc + 1;
    sb.push_back(e);
    e.start_edge = cyc + 1 + LAT + 1;
    sb.push_back(e);
    start = 1'b1; seed = 16'h2468;
    repeat (LAT + 2) @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-carve, with a start in the same cycle
    @(negedge clk);
    start = 1'b1; seed = 16'h1357;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start_with_rst_ignored", busy, 1'b0);
    issue(16'h1357); drain();

    for (int i = 0; i < 20; i++) begin
      issue(16'($urandom));
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
